// File: rtl/pb_debounce_pkg.sv
// Shared definitions for the pushbutton debounce/select block.
// Holds the per-channel state encoding and the default debounce length,
// which is 10 ms at the 50 MHz board clock.
package pb_debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,  // stable, not pressed
    PRESS_WAIT   = 2'd1,  // synchronised level low, qualifying the press
    PRESSED      = 2'd2,  // stable, pressed
    RELEASE_WAIT = 2'd3   // synchronised level high, qualifying the release
  } pb_state_e;

endpackage

// File: rtl/pb_debounce_channel.sv
// One pushbutton channel: two-flop synchroniser, debounce counter, state
// machine and the registered toggle-select bit.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   pb          raw pushbutton, active-low, asynchronous to clk
//   sel         toggle state, flips on every accepted press
//   press_pulse one-cycle strobe on an accepted press
//   pb_level    debounced level, 1 = pressed
module pb_debounce_channel
  import pb_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic sel,
  output logic press_pulse,
  output logic pb_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          pb_s;
  pb_state_e     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          sel_reg, sel_next;
  logic          pulse_reg, pulse_next;

  // Synchroniser resets to 1 so a reset looks like a released button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 2'b11;
    else        sync_reg <= {sync_reg[0], pb};
  end

  assign pb_s = sync_reg[1];

  // The counter is cleared on every state entry, so it never needs to wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    pulse_next = 1'b0;
    case (state_reg)
      RELEASED: begin
        if (!pb_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (pb_s) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          // sel and the pulse update together so the mux sees the new
          // selection on the pulse cycle.
          state_next = PRESSED;
          cnt_next   = '0;
          sel_next   = ~sel_reg;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      PRESSED: begin
        if (pb_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!pb_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      sel_reg   <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      pulse_reg <= pulse_next;
    end
  end

  assign sel         = sel_reg;
  assign press_pulse = pulse_reg;
  assign pb_level    = (state_reg == PRESSED) || (state_reg == RELEASE_WAIT);

endmodule

// File: rtl/pb_debounce_select.sv
// Pushbutton receiver for the operation-select path: NUM_PB independent
// debounced channels, each producing a toggle select bit, a one-cycle press
// strobe and a debounced level. All outputs come from registers.
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   PB          raw pushbuttons, active-low
//   sel         per-button toggle state to the multiplexer select
//   press_pulse per-button one-cycle accepted-press strobe
//   pb_level    per-button debounced level, 1 = pressed
module pb_debounce_select
  import pb_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int NUM_PB          = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] PB,
  output logic [NUM_PB-1:0] sel,
  output logic [NUM_PB-1:0] press_pulse,
  output logic [NUM_PB-1:0] pb_level
);

  generate
    for (genvar gi = 0; gi < NUM_PB; gi++) begin : g_ch
      pb_debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .pb         (PB[gi]),
        .sel        (sel[gi]),
        .press_pulse(press_pulse[gi]),
        .pb_level   (pb_level[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pb_debounce_select.sv
// Directed bench for pb_debounce_select with DEBOUNCE_CYCLES = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// so the sample taken i falling edges after a change reflects rising edge i.
module tb_pb_debounce_select;

  logic       clk;
  logic       rst_n;
  logic [1:0] pb;
  logic [1:0] sel;
  logic [1:0] press_pulse;
  logic [1:0] pb_level;

  int n_cmp = 0;
  int n_bad = 0;

  pb_debounce_select #(
    .DEBOUNCE_CYCLES(4),
    .NUM_PB         (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PB         (pb),
    .sel        (sel),
    .press_pulse(press_pulse),
    .pb_level   (pb_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    pb    = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    pb    = 2'b11;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sel, press_pulse, pb_level} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_state: got sel=%b pulse=%b level=%b, want all 0", sel, press_pulse, pb_level);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({sel, press_pulse, pb_level} !== 6'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got sel=%b pulse=%b level=%b, want all 0", sel, press_pulse, pb_level);
    end
    $display("test_reset done");
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    apply_reset();
    pb = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (press_pulse[0]) pulses++;
      if (i == 6) begin
        n_cmp++;
        if ({press_pulse, pb_level, sel} !== 6'b000000) begin
          n_bad++;
          $display("FAIL press_edge6: got pulse=%b level=%b sel=%b, want 00 00 00", press_pulse, pb_level, sel);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({press_pulse, pb_level, sel} !== 6'b010101) begin
          n_bad++;
          $display("FAIL press_edge7: got pulse=%b level=%b sel=%b, want 01 01 01", press_pulse, pb_level, sel);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (press_pulse !== 2'b00) begin
          n_bad++;
          $display("FAIL press_edge8_pulse: got %b, want 00", press_pulse);
        end
      end
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL press_pulse_count: got %0d, want 1", pulses);
    end
    $display("test_clean_press done: pulses=%0d sel=%b", pulses, sel);
  endtask

  task automatic test_bounce();
    int   pulses = 0;
    logic level_seen = 1'b0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      pb[0] = (i < 30) ? (((i / 2) % 2) != 0) : 1'b1;
      @(negedge clk);
      if (press_pulse != 2'b00) pulses++;
      if (pb_level != 2'b00) level_seen = 1'b1;
    end
    n_cmp++;
    if (pulses !== 0 || level_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce_outputs: got pulses=%0d level_seen=%b, want 0 0", pulses, level_seen);
    end
    n_cmp++;
    if (sel !== 2'b00) begin
      n_bad++;
      $display("FAIL bounce_sel: got %b, want 00", sel);
    end
    $display("test_bounce done: pulses=%0d", pulses);
  endtask

  task automatic test_toggle_seq();
    int   pulses1 = 0;
    int   pulses0 = 0;
    logic exp_sel1 = 1'b0;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      pb[1] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (press_pulse[1]) pulses1++;
        if (press_pulse[0]) pulses0++;
      end
      exp_sel1 = ~exp_sel1;
      n_cmp++;
      if (sel !== {exp_sel1, 1'b0}) begin
        n_bad++;
        $display("FAIL toggle_sel_press%0d: got %b, want %b", k, sel, {exp_sel1, 1'b0});
      end
      pb[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (press_pulse[1]) pulses1++;
        if (press_pulse[0]) pulses0++;
      end
    end
    n_cmp++;
    if (pulses1 !== 3 || pulses0 !== 0) begin
      n_bad++;
      $display("FAIL toggle_pulse_count: got pb1=%0d pb0=%0d, want 3 0", pulses1, pulses0);
    end
    $display("test_toggle_seq done: pulses=%0d sel=%b", pulses1, sel);
  endtask

  task automatic test_release_debounce();
    int   pulses = 0;
    logic level_dropped = 1'b0;
    apply_reset();
    pb[0] = 1'b0;
    repeat (10) @(negedge clk);
    // Short release excursion of 3 samples must be ignored.
    for (int i = 0; i < 15; i++) begin
      pb[0] = (i < 3);
      @(negedge clk);
      if (press_pulse != 2'b00) pulses++;
      if (pb_level[0] !== 1'b1) level_dropped = 1'b1;
    end
    n_cmp++;
    if (pulses !== 0 || level_dropped !== 1'b0) begin
      n_bad++;
      $display("FAIL release_glitch: got pulses=%0d dropped=%b, want 0 0", pulses, level_dropped);
    end
    pb[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) begin
        n_cmp++;
        if (pb_level !== 2'b01) begin
          n_bad++;
          $display("FAIL release_edge6_level: got %b, want 01", pb_level);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (pb_level !== 2'b00 || press_pulse !== 2'b00 || sel !== 2'b01) begin
          n_bad++;
          $display("FAIL release_edge7: got level=%b pulse=%b sel=%b, want 00 00 01", pb_level, press_pulse, sel);
        end
      end
    end
    $display("test_release_debounce done: level=%b sel=%b", pb_level, sel);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    pb = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) begin
        n_cmp++;
        if (press_pulse !== 2'b00 || sel !== 2'b00) begin
          n_bad++;
          $display("FAIL simul_edge6: got pulse=%b sel=%b, want 00 00", press_pulse, sel);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (press_pulse !== 2'b11 || sel !== 2'b11 || pb_level !== 2'b11) begin
          n_bad++;
          $display("FAIL simul_edge7: got pulse=%b sel=%b level=%b, want 11 11 11", press_pulse, sel, pb_level);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (press_pulse !== 2'b00) begin
          n_bad++;
          $display("FAIL simul_edge8_pulse: got %b, want 00", press_pulse);
        end
      end
    end
    $display("test_simultaneous done: sel=%b", sel);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    pb[0] = 1'b0;
    repeat (10) @(negedge clk);
    pb[0] = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (sel !== 2'b01) begin
      n_bad++;
      $display("FAIL rstmid_setup_sel: got %b, want 01", sel);
    end
    // Second press, interrupted while qualifying.
    pb[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sel, press_pulse, pb_level} !== 6'b0) begin
      n_bad++;
      $display("FAIL rstmid_async: got sel=%b pulse=%b level=%b, want all 0", sel, press_pulse, pb_level);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 6) begin
        n_cmp++;
        if (press_pulse !== 2'b00 || sel !== 2'b00) begin
          n_bad++;
          $display("FAIL rstmid_edge6: got pulse=%b sel=%b, want 00 00", press_pulse, sel);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (press_pulse !== 2'b01 || sel !== 2'b01) begin
          n_bad++;
          $display("FAIL rstmid_edge7: got pulse=%b sel=%b, want 01 01", press_pulse, sel);
        end
      end
    end
    $display("test_reset_mid done: sel=%b", sel);
  endtask

  initial begin
    rst_n = 1'b0;
    pb    = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_toggle_seq();
    test_release_debounce();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
